// File: rtl/demux_1a2_fifo_pkg.sv
// Shared defaults and lane encoding for the 1:2 byte de-interleaver.
package demux_1a2_fifo_pkg;

    localparam int unsigned DEMUX_WIDTH = 8;
    localparam int unsigned DEMUX_DEPTH = 4;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    function automatic lane_e next_lane(input lane_e cur);
        return (cur == LANE0) ? LANE1 : LANE0;
    endfunction

endpackage

// File: rtl/demux_1a2_fifo_fifo_sync.sv
// Show-ahead synchronous FIFO with extra-MSB pointers; one per output lane.
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the head byte reads as zero while empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/demux_1a2_fifo.sv
// De-interleaves one byte stream into two lane FIFOs with valid/ready on every side.
// Optional per-lane push counters are built when DEMUX_STATS_EN is defined.
module demux_1a2_fifo
    import demux_1a2_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEMUX_WIDTH,
    parameter int unsigned DEPTH = DEMUX_DEPTH
`ifdef DEMUX_STATS_EN
    ,
    parameter int unsigned CW = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out_0,
    output logic             valid_out_0,
    input  logic             ready_in_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out_1,
    input  logic             ready_in_1
`ifdef DEMUX_STATS_EN
    ,
    output logic [CW-1:0]    cnt_0,
    output logic [CW-1:0]    cnt_1
`endif
);

    lane_e sel;
    logic  empty_0, full_0, empty_1, full_1;
    logic  accept, push_0, push_1, pop_0, pop_1;

    // Ready depends only on registered state, never on valid_in.
    assign ready_out   = (sel == LANE0) ? !full_0 : !full_1;
    assign accept      = valid_in && ready_out;
    assign push_0      = accept && (sel == LANE0);
    assign push_1      = accept && (sel == LANE1);
    assign valid_out_0 = !empty_0;
    assign valid_out_1 = !empty_1;
    assign pop_0       = valid_out_0 && ready_in_0;
    assign pop_1       = valid_out_1 && ready_in_1;

    // Lane pointer advances only on an accepted word so idle cycles never skip a lane.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel <= LANE0;
        end else if (accept) begin
            sel <= next_lane(sel);
        end
    end

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_0 (
        .clk   (clk),
        .reset (reset),
        .push  (push_0),
        .din   (data_in),
        .pop   (pop_0),
        .dout  (data_out_0),
        .empty (empty_0),
        .full  (full_0)
    );

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_1 (
        .clk   (clk),
        .reset (reset),
        .push  (push_1),
        .din   (data_in),
        .pop   (pop_1),
        .dout  (data_out_1),
        .empty (empty_1),
        .full  (full_1)
    );

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (push_0) cnt_0 <= cnt_0 + CW'(1);
            if (push_1) cnt_1 <= cnt_1 + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux_1a2_fifo.sv
// Directed bench for demux_1a2_fifo; exercises the stats counters when DEMUX_STATS_EN is defined.
module tb_demux_1a2_fifo;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] data_out_0, data_out_1;
    logic         valid_out_0, valid_out_1;
    logic         ready_in_0, ready_in_1;
`ifdef DEMUX_STATS_EN
    logic [CW-1:0] cnt_0, cnt_1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_1a2_fifo #(
        .WIDTH(W),
        .DEPTH(4)
`ifdef DEMUX_STATS_EN
        ,
        .CW(CW)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out_0  (data_out_0),
        .valid_out_0 (valid_out_0),
        .ready_in_0  (ready_in_0),
        .data_out_1  (data_out_1),
        .valid_out_1 (valid_out_1),
        .ready_in_1  (ready_in_1)
`ifdef DEMUX_STATS_EN
        ,
        .cnt_0       (cnt_0),
        .cnt_1       (cnt_1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        valid_in   = 1'b1;
        data_in    = 8'h55;
        ready_in_0 = 1'b1;
        ready_in_1 = 1'b1;

        // Reset held with valid_in asserted: nothing may be pushed.
        tick();
        tick();
        check("rst_valid0", 32'(valid_out_0), 32'd0);
        check("rst_valid1", 32'(valid_out_1), 32'd0);
        check("rst_ready",  32'(ready_out),   32'd1);
        check("rst_data0",  32'(data_out_0),  32'd0);
        check("rst_data1",  32'(data_out_1),  32'd0);
        valid_in = 1'b0;
        reset    = 1'b1;
        tick();

        // Back-to-back stream, sinks always ready.
        valid_in = 1'b1;
        data_in  = 8'hA0;
        tick();
        check("s_a0_valid", 32'(valid_out_0), 32'd1);
        check("s_a0_data",  32'(data_out_0),  32'hA0);
        check("s_a0_l1",    32'(valid_out_1), 32'd0);
        data_in = 8'hB0;
        tick();
        check("s_b0_data",  32'(data_out_1),  32'hB0);
        check("s_b0_l0",    32'(valid_out_0), 32'd0);
        data_in = 8'hA1;
        tick();
        check("s_a1_data",  32'(data_out_0),  32'hA1);
        check("s_a1_l1",    32'(valid_out_1), 32'd0);
        data_in = 8'hB1;
        tick();
        check("s_b1_data",  32'(data_out_1),  32'hB1);
        valid_in = 1'b0;
        tick();
        check("s_drain0",   32'(valid_out_0), 32'd0);
        check("s_drain1",   32'(valid_out_1), 32'd0);

        // Idle gaps must not advance the lane pointer.
        valid_in = 1'b1;
        data_in  = 8'h11;
        tick();
        check("g_11", 32'(data_out_0), 32'h11);
        valid_in = 1'b0;
        data_in  = 8'hEE;
        repeat (3) tick();
        check("g_idle_l1", 32'(valid_out_1), 32'd0);
        check("g_ready",   32'(ready_out),   32'd1);
        valid_in = 1'b1;
        data_in  = 8'h22;
        tick();
        check("g_22_l1", 32'(data_out_1),  32'h22);
        check("g_22_l0", 32'(valid_out_0), 32'd0);
        valid_in = 1'b0;
        tick();

        // Backpressure: lane 0 stalled, lane 1 draining.
        ready_in_0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(i);
            check($sformatf("bp_ready_%0d", i), 32'(ready_out), 32'd1);
            tick();
            if (i % 2 == 1) begin
                check($sformatf("bp_l1_%0d", i), 32'(data_out_1), 32'(i));
            end
        end
        data_in = 8'h08;
        check("bp_stall", 32'(ready_out), 32'd0);
        repeat (3) tick();
        check("bp_stall_hold", 32'(ready_out),   32'd0);
        check("bp_head_hold",  32'(data_out_0),  32'h00);
        check("bp_l1_empty",   32'(valid_out_1), 32'd0);

        // Full lane popped at the same edge the input targets it: push refused this cycle.
        ready_in_0 = 1'b1;
        check("fp_refuse", 32'(ready_out), 32'd0);
        tick();
        check("fp_head02", 32'(data_out_0), 32'h02);
        check("fp_ready",  32'(ready_out),  32'd1);
        tick();
        check("fp_head04", 32'(data_out_0), 32'h04);
        data_in = 8'h09;
        tick();
        check("fp_head06", 32'(data_out_0), 32'h06);
        check("fp_l1_09",  32'(data_out_1), 32'h09);
        valid_in = 1'b0;
        tick();
        check("fp_head08", 32'(data_out_0),  32'h08);
        check("fp_l1_emp", 32'(valid_out_1), 32'd0);
        tick();
        check("fp_l0_emp", 32'(valid_out_0), 32'd0);

        // Asynchronous reset mid-operation drops stored data immediately.
        ready_in_0 = 1'b0;
        valid_in   = 1'b1;
        data_in    = 8'h77;
        tick();
        valid_in = 1'b0;
        check("mr_pre", 32'(valid_out_0), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_valid0", 32'(valid_out_0), 32'd0);
        check("mr_data0",  32'(data_out_0),  32'd0);
        tick();
        reset      = 1'b1;
        ready_in_0 = 1'b1;
        valid_in   = 1'b1;
        data_in    = 8'h33;
        tick();
        check("mr_sel0", 32'(data_out_0), 32'h33);
        valid_in = 1'b0;
        tick();

`ifdef DEMUX_STATS_EN
        // 2*2^CW+3 alternating pushes wrap both counters.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("st_rst0", 32'(cnt_0), 32'd0);
        valid_in = 1'b1;
        for (int i = 0; i < 35; i++) begin
            data_in = 8'(i);
            tick();
        end
        valid_in = 1'b0;
        tick();
        check("st_cnt0", 32'(cnt_0), 32'd2);
        check("st_cnt1", 32'(cnt_1), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
